// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory port arbiter.
// Build option MEM_ARB_RR_EN (see mem_port_arbiter) does not affect this package.
package mem_arb_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IRD,
        ST_DRD,
        ST_DWR,
        ST_RMW_RD,
        ST_RMW_WR
    } arb_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    localparam logic [DATA_W-1:0] DEFAULT_BASE_ADDR = 32'h0100_0000;

    // Size code 11 has no legal alignment, so it always reports misaligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] byte_off);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = byte_off[0];
            SIZE_WORD: bad = (byte_off != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [DATA_W-1:0] word_align(input logic [DATA_W-1:0] addr);
        return {addr[DATA_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_store_merge.sv
// Combinational lane merge for sub-word stores: replaces the addressed byte/half
// of the previously read word with right-justified store data.
module mem_store_merge
    import mem_arb_pkg::*;
(
    input  logic [DATA_W-1:0] old_word,
    input  logic [DATA_W-1:0] wdata,
    input  logic [1:0]        size,
    input  logic [1:0]        byte_off,
    output logic [DATA_W-1:0] merged
);

    always_comb begin
        merged = old_word;
        case (size)
            SIZE_BYTE: begin
                case (byte_off)
                    2'd0:    merged[7:0]   = wdata[7:0];
                    2'd1:    merged[15:8]  = wdata[7:0];
                    2'd2:    merged[23:16] = wdata[7:0];
                    default: merged[31:24] = wdata[7:0];
                endcase
            end
            SIZE_HALF: begin
                if (byte_off[1]) merged[31:16] = wdata[15:0];
                else             merged[15:0]  = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store ports onto the single-port word memory, with
// read-modify-write for sub-word stores. Define MEM_ARB_RR_EN for round-robin arbitration.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter logic [DATA_W-1:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              imem_req,
    input  logic [DATA_W-1:0] imem_addr,
    output logic              imem_gnt,
    output logic              imem_rvalid,
    output logic [DATA_W-1:0] imem_rdata,
    input  logic              dmem_req,
    input  logic              dmem_we,
    input  logic [1:0]        dmem_size,
    input  logic [DATA_W-1:0] dmem_addr,
    input  logic [DATA_W-1:0] dmem_wdata,
    output logic              dmem_gnt,
    output logic              dmem_rvalid,
    output logic [DATA_W-1:0] dmem_rdata,
    output logic              dmem_err,
    output logic [DATA_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              mem_read_write
);

    arb_state_t        state, state_nxt;
    logic [DATA_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [1:0]        req_size;
    logic [DATA_W-1:0] rmw_word;
    logic [DATA_W-1:0] merged_word;
    logic              pick_i, pick_d;
    logic              d_misaligned;
    logic              contended;

    assign d_misaligned = is_misaligned(dmem_size, dmem_addr[1:0]);
    assign contended    = (state == ST_IDLE) && imem_req && dmem_req;

`ifdef MEM_ARB_RR_EN
    // Winner of the last contended grant; reset value makes data win the first contention.
    logic last_win_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)          last_win_d <= 1'b0;
        else if (contended) last_win_d <= pick_d;
    end
`endif

    // Grants are only offered in IDLE and are suppressed while reset is held.
    always_comb begin
        pick_i = 1'b0;
        pick_d = 1'b0;
        if (state == ST_IDLE && !reset) begin
            if (contended) begin
`ifdef MEM_ARB_RR_EN
                if (last_win_d) pick_i = 1'b1;
                else            pick_d = 1'b1;
`else
                pick_d = 1'b1;
`endif
            end else begin
                pick_i = imem_req;
                pick_d = dmem_req;
            end
        end
    end

    assign imem_gnt = pick_i;
    assign dmem_gnt = pick_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE: begin
                if (pick_d) begin
                    if (d_misaligned)              state_nxt = ST_IDLE;
                    else if (!dmem_we)             state_nxt = ST_DRD;
                    else if (dmem_size == SIZE_WORD) state_nxt = ST_DWR;
                    else                           state_nxt = ST_RMW_RD;
                end else if (pick_i) begin
                    state_nxt = ST_IRD;
                end
            end
            ST_RMW_RD: state_nxt = ST_RMW_WR;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Memory controls are decoded from state so an asserted reset cancels any write at once.
    always_comb begin
        mem_address    = BASE_ADDR;
        mem_data_in    = '0;
        mem_read_write = MEM_READ;
        case (state)
            ST_IRD, ST_DRD, ST_RMW_RD: begin
                mem_address = word_align(req_addr);
            end
            ST_DWR: begin
                mem_address    = word_align(req_addr);
                mem_data_in    = req_wdata;
                mem_read_write = MEM_WRITE;
            end
            ST_RMW_WR: begin
                mem_address    = word_align(req_addr);
                mem_data_in    = merged_word;
                mem_read_write = MEM_WRITE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (pick_d) begin
            req_addr  <= dmem_addr;
            req_wdata <= dmem_wdata;
            req_size  <= dmem_size;
        end else if (pick_i) begin
            req_addr <= imem_addr;
        end
        if (state == ST_RMW_RD) rmw_word <= mem_data_out;
    end

    mem_store_merge u_merge (
        .old_word (rmw_word),
        .wdata    (req_wdata),
        .size     (req_size),
        .byte_off (req_addr[1:0]),
        .merged   (merged_word)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            imem_rvalid <= 1'b0;
            imem_rdata  <= '0;
            dmem_rvalid <= 1'b0;
            dmem_rdata  <= '0;
            dmem_err    <= 1'b0;
        end else begin
            imem_rvalid <= (state == ST_IRD);
            dmem_rvalid <= (state == ST_DRD) || (state == ST_DWR) || (state == ST_RMW_WR);
            dmem_err    <= pick_d && d_misaligned;
            if (state == ST_IRD) imem_rdata <= mem_data_out;
            if (state == ST_DRD) dmem_rdata <= mem_data_out;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a behavioural word memory and
// response scoreboards; arbitration expectations follow MEM_ARB_RR_EN.
module tb_mem_port_arbiter;

    localparam logic [31:0] BASE = 32'h0100_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt, imem_rvalid;
    logic [31:0] imem_rdata;
    logic        dmem_req, dmem_we;
    logic [1:0]  dmem_size;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_gnt, dmem_rvalid, dmem_err;
    logic [31:0] dmem_rdata;
    logic [31:0] mem_address, mem_data_in, mem_data_out;
    logic        mem_read_write;

    mem_port_arbiter dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_size      (dmem_size),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_gnt       (dmem_gnt),
        .dmem_rvalid    (dmem_rvalid),
        .dmem_rdata     (dmem_rdata),
        .dmem_err       (dmem_err),
        .mem_address    (mem_address),
        .mem_data_in    (mem_data_in),
        .mem_data_out   (mem_data_out),
        .mem_read_write (mem_read_write)
    );

    always #5 clock = ~clock;

    // Word memory: combinational read, write on posedge.
    logic [31:0] mem [0:255];
    int          wr_cycles = 0;
    int          cyc = 0;
    assign mem_data_out = mem[mem_address[9:2]];

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (mem_read_write) begin
            mem[mem_address[9:2]] <= mem_data_in;
            wr_cycles <= wr_cycles + 1;
        end
    end

    typedef struct {
        logic        err;
        logic        chk_data;
        logic [31:0] data;
    } dexp_t;

    dexp_t       dq[$];
    logic [31:0] iq[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          last_irv_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Response monitor: pops the scoreboard whenever the DUT reports completion.
    always @(negedge clock) begin
        if (!reset) begin
            if (imem_rvalid) begin
                last_irv_cyc = cyc;
                if (iq.size() == 0) chk("imem_rvalid_unexpected", 1, 0);
                else                chk("imem_rdata", imem_rdata, iq.pop_front());
            end
            if (dmem_rvalid || dmem_err) begin
                if (dq.size() == 0) begin
                    chk("dmem_resp_unexpected", 1, 0);
                end else begin
                    dexp_t e;
                    e = dq.pop_front();
                    chk("dmem_err", {31'b0, dmem_err}, {31'b0, e.err});
                    chk("dmem_rvalid", {31'b0, dmem_rvalid}, {31'b0, ~e.err});
                    if (e.chk_data) chk("dmem_rdata", dmem_rdata, e.data);
                end
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 50 && (iq.size() != 0 || dq.size() != 0); i++) @(negedge clock);
        if (iq.size() != 0 || dq.size() != 0) begin
            chk("drain_timeout", 1, 0);
            iq.delete();
            dq.delete();
        end
    endtask

    task automatic wait_dgnt(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clock);
            ok = dmem_gnt;
        end
        if (!ok) chk("dmem_gnt_timeout", 1, 0);
    endtask

    task automatic d_access(input logic we, input logic [1:0] sz, input logic [31:0] addr,
                            input logic [31:0] wd, input logic err, input logic [31:0] rd);
        logic ok;
        dexp_t e;
        @(posedge clock); #1;
        dmem_we = we; dmem_size = sz; dmem_addr = addr; dmem_wdata = wd; dmem_req = 1'b1;
        wait_dgnt(ok);
        if (ok) begin
            e.err = err; e.chk_data = !we && !err; e.data = rd;
            dq.push_back(e);
        end
        @(posedge clock); #1;
        dmem_req = 1'b0;
        drain();
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rd;
        int          nwr;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    initial begin
        logic ok;
        int   w0, g, gcyc;
        logic exp_d [4];
        logic got_d [4];

        vecs[0]  = '{1'b1, 2'b10, BASE + 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0,         1};
        vecs[1]  = '{1'b0, 2'b10, BASE + 32'h10, 32'h0,         1'b0, 32'hDEAD_BEEF, 0};
        vecs[2]  = '{1'b1, 2'b10, BASE + 32'h20, 32'h1122_3344, 1'b0, 32'h0,         1};
        vecs[3]  = '{1'b1, 2'b00, BASE + 32'h22, 32'hFFFF_FFAA, 1'b0, 32'h0,         1};
        vecs[4]  = '{1'b0, 2'b00, BASE + 32'h23, 32'h0,         1'b0, 32'h11AA_3344, 0};
        vecs[5]  = '{1'b1, 2'b10, BASE + 32'h24, 32'hCAFE_F00D, 1'b0, 32'h0,         1};
        vecs[6]  = '{1'b1, 2'b01, BASE + 32'h26, 32'h1234_5566, 1'b0, 32'h0,         1};
        vecs[7]  = '{1'b1, 2'b00, BASE + 32'h24, 32'h0000_0099, 1'b0, 32'h0,         1};
        vecs[8]  = '{1'b0, 2'b10, BASE + 32'h24, 32'h0,         1'b0, 32'h5566_F099, 0};
        vecs[9]  = '{1'b1, 2'b01, BASE + 32'h03, 32'h0000_7777, 1'b1, 32'h0,         0};
        vecs[10] = '{1'b1, 2'b10, BASE + 32'h22, 32'h5555_5555, 1'b1, 32'h0,         0};
        vecs[11] = '{1'b0, 2'b11, BASE + 32'h20, 32'h0,         1'b1, 32'h0,         0};
        vecs[12] = '{1'b0, 2'b10, BASE + 32'h20, 32'h0,         1'b0, 32'h11AA_3344, 0};

        for (int i = 0; i < 256; i++) mem[i] = 32'hA5A5_0000 | i;
        mem[0]  = 32'h0BAD_F00D;
        mem[2]  = 32'h0041_0113;
        mem[12] = 32'h0102_0304;

        imem_req = 0; imem_addr = 0;
        dmem_req = 0; dmem_we = 0; dmem_size = 0; dmem_addr = 0; dmem_wdata = 0;
        reset = 1'b1;
        #1;
        chk("rst_imem_gnt",    {31'b0, imem_gnt},       0);
        chk("rst_dmem_gnt",    {31'b0, dmem_gnt},       0);
        chk("rst_imem_rvalid", {31'b0, imem_rvalid},    0);
        chk("rst_dmem_rvalid", {31'b0, dmem_rvalid},    0);
        chk("rst_dmem_err",    {31'b0, dmem_err},       0);
        chk("rst_imem_rdata",  imem_rdata,              0);
        chk("rst_dmem_rdata",  dmem_rdata,              0);
        chk("rst_mem_rw",      {31'b0, mem_read_write}, 0);
        chk("rst_mem_address", mem_address,             BASE);
        chk("rst_mem_data_in", mem_data_in,             0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Fetch only: grant in c0, rvalid in c2.
        @(posedge clock); #1;
        imem_addr = BASE + 32'h08; imem_req = 1'b1;
        ok = 1'b0; gcyc = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clock);
            ok = imem_gnt;
        end
        if (!ok) chk("imem_gnt_timeout", 1, 0);
        else begin
            gcyc = cyc;
            iq.push_back(32'h0041_0113);
        end
        @(posedge clock); #1 imem_req = 1'b0;
        drain();
        chk("fetch_latency", last_irv_cyc - gcyc, 2);

        // Data-port vector table.
        for (int k = 0; k < NV; k++) begin
            w0 = wr_cycles;
            d_access(vecs[k].we, vecs[k].sz, vecs[k].addr, vecs[k].wdata, vecs[k].err, vecs[k].rd);
            chk($sformatf("vec%0d_write_cycles", k), wr_cycles - w0, vecs[k].nwr);
        end
        chk("misaligned_mem_unchanged", mem[0], 32'h0BAD_F00D);

        // Reset while the RMW read is in progress.
        w0 = wr_cycles;
        @(posedge clock); #1;
        dmem_we = 1'b1; dmem_size = 2'b00; dmem_addr = BASE + 32'h31; dmem_wdata = 32'h0000_00EE;
        dmem_req = 1'b1;
        wait_dgnt(ok);
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        chk("midrst_mem_rw",      {31'b0, mem_read_write}, 0);
        chk("midrst_mem_address", mem_address,             BASE);
        chk("midrst_mem_data_in", mem_data_in,             0);
        chk("midrst_dmem_gnt",    {31'b0, dmem_gnt},       0);
        chk("midrst_dmem_rdata",  dmem_rdata,              0);
        chk("midrst_dmem_rvalid", {31'b0, dmem_rvalid},    0);
        repeat (2) @(posedge clock);
        chk("midrst_word_kept", mem[12], 32'h0102_0304);
        chk("midrst_no_write", wr_cycles - w0, 0);
        dq.delete();
        #1 reset = 1'b0;
        wait_dgnt(ok);
        if (ok) dq.push_back('{1'b0, 1'b0, 32'h0});
        @(posedge clock); #1 dmem_req = 1'b0;
        drain();
        chk("regrant_word", mem[12], 32'h0102_EE04);
        chk("regrant_write_cycles", wr_cycles - w0, 1);

        // Both ports request continuously; first contention since reset.
`ifdef MEM_ARB_RR_EN
        exp_d[0] = 1'b1; exp_d[1] = 1'b0; exp_d[2] = 1'b1; exp_d[3] = 1'b0;
`else
        exp_d[0] = 1'b1; exp_d[1] = 1'b1; exp_d[2] = 1'b1; exp_d[3] = 1'b1;
`endif
        for (int i = 0; i < 4; i++) got_d[i] = 1'bx;
        @(posedge clock); #1;
        imem_addr = BASE + 32'h08; imem_req = 1'b1;
        dmem_we = 1'b0; dmem_size = 2'b10; dmem_addr = BASE + 32'h10; dmem_req = 1'b1;
        g = 0;
        for (int c = 0; c < 40 && g < 4; c++) begin
            @(negedge clock);
            if (imem_gnt && dmem_gnt) chk("double_grant", 1, 0);
            if (dmem_gnt) begin
                got_d[g] = 1'b1; g++;
                dq.push_back('{1'b0, 1'b1, mem[4]});
            end else if (imem_gnt) begin
                got_d[g] = 1'b0; g++;
                iq.push_back(mem[2]);
            end
        end
        @(posedge clock); #1;
        imem_req = 1'b0; dmem_req = 1'b0;
        drain();
        for (int i = 0; i < 4; i++)
            chk($sformatf("arb_grant%0d_is_data", i), {31'b0, got_d[i]}, {31'b0, exp_d[i]});

        repeat (2) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
